// File: rtl/procesador_pkg.sv
// Shared types for the Procesador control unit: opcodes, FSM states,
// ALU/shifter function codes and the packed datapath control word.
package procesador_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_ADI = 4'h6,
        OP_MOV = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_LD  = 4'hA,
        OP_ST  = 4'hB,
        OP_BRZ = 4'hC,
        OP_BRN = 4'hD,
        OP_JMP = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_PAUSE
    } state_e;

    localparam logic [3:0] G_PASS_A = 4'b0000;
    localparam logic [3:0] G_ADD    = 4'b0010;
    localparam logic [3:0] G_SUB    = 4'b0101;
    localparam logic [3:0] G_AND    = 4'b1000;
    localparam logic [3:0] G_OR     = 4'b1010;
    localparam logic [3:0] G_XOR    = 4'b1100;

    localparam logic [1:0] H_PASS = 2'b00;
    localparam logic [1:0] H_SHL  = 2'b01;
    localparam logic [1:0] H_SHR  = 2'b10;
    localparam logic [1:0] H_ZERO = 2'b11;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [1:0] dest_sel;
        logic [1:0] h_sel;
        logic [3:0] g_sel;
        logic       mb_sel;
        logic       md_sel;
        logic       mf_sel;
        logic       load_en;
        logic       mem_wr;
    } ctrl_word_t;

    // ALU and shifter opcodes are the ones whose result flags get latched.
    function automatic logic op_writes_flags(input opcode_e op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/procesador_decoder.sv
// Combinational instruction decoder: IR -> datapath control word and immediate.
// The caller is responsible for gating the result to the EXEC cycle.
module procesador_decoder
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic [2*m-1:0] ir,
    output ctrl_word_t     ctrl,
    output logic [m-1:0]   cons_in
);

    opcode_e      op;
    logic [1:0]   dr;
    logic [1:0]   sa;
    logic [1:0]   sb;
    logic [m-1:0] imm;

    always_comb begin
        op      = opcode_e'(ir[2*m-1 -: 4]);
        dr      = ir[2*m-5 -: 2];
        sa      = ir[2*m-7 -: 2];
        imm     = ir[m-1:0];
        sb      = imm[1:0];
        ctrl    = '0;
        cons_in = '0;

        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADI: begin
                ctrl.dest_sel = dr;
                ctrl.a_sel    = sa;
                ctrl.b_sel    = sb;
                ctrl.load_en  = 1'b1;
                case (op)
                    OP_SUB:  ctrl.g_sel = G_SUB;
                    OP_AND:  ctrl.g_sel = G_AND;
                    OP_OR:   ctrl.g_sel = G_OR;
                    OP_XOR:  ctrl.g_sel = G_XOR;
                    default: ctrl.g_sel = G_ADD;
                endcase
                if (op == OP_ADI) begin
                    ctrl.mb_sel = 1'b1;
                    cons_in     = imm;
                end
            end
            OP_MOV: begin
                ctrl.dest_sel = dr;
                ctrl.a_sel    = sa;
                ctrl.g_sel    = G_PASS_A;
                ctrl.load_en  = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                ctrl.dest_sel = dr;
                ctrl.b_sel    = sb;
                ctrl.mf_sel   = 1'b1;
                ctrl.h_sel    = (op == OP_SHL) ? H_SHL : H_SHR;
                ctrl.load_en  = 1'b1;
            end
            OP_LD: begin
                ctrl.dest_sel = dr;
                ctrl.a_sel    = sa;
                ctrl.md_sel   = 1'b1;
                ctrl.load_en  = 1'b1;
            end
            OP_ST: begin
                ctrl.a_sel  = sa;
                ctrl.b_sel  = sb;
                ctrl.mem_wr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/procesador_control_unit.sv
// Fetch/decode/execute sequencer driving the Procesador datapath control word.
// Define PROCESADOR_STEP_EN to add the step input and a PAUSE state after each EXEC.
module procesador_control_unit
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
`ifdef PROCESADOR_STEP_EN
    input  logic           step,
`endif
    output logic           imem_req,
    output logic [m-1:0]   imem_addr,
    input  logic           imem_valid,
    input  logic [2*m-1:0] imem_data,
    input  logic [3:0]     Tags,
    output logic [1:0]     A_sel,
    output logic [1:0]     B_sel,
    output logic [1:0]     Dest_sel,
    output logic [1:0]     H_sel,
    output logic [3:0]     G_sel,
    output logic           MB_sel,
    output logic           MD_sel,
    output logic           MF_sel,
    output logic           Load_en,
    output logic [m-1:0]   Cons_IN,
    output logic           mem_wr,
    output logic           halted
);

    state_e         state_q, state_d;
    logic [m-1:0]   pc_q, pc_d;
    logic [2*m-1:0] ir_q, ir_d;
    logic [3:0]     flags_q, flags_d;
    logic           halted_q, halted_d;
    logic           imem_req_q, imem_req_d;
    ctrl_word_t     ctrl_q, ctrl_d;
    logic [m-1:0]   cons_q, cons_d;

    ctrl_word_t     dec_ctrl;
    logic [m-1:0]   dec_cons;
    opcode_e        op;
    logic [m-1:0]   imm;
    logic           unused_flags;

    procesador_decoder #(.m(m)) u_decoder (
        .ir      (ir_q),
        .ctrl    (dec_ctrl),
        .cons_in (dec_cons)
    );

    assign op           = opcode_e'(ir_q[2*m-1 -: 4]);
    assign imm          = ir_q[m-1:0];
    assign unused_flags = ^flags_q[3:2];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flags_d    = flags_q;
        halted_d   = halted_q;
        imem_req_d = 1'b0;
        ctrl_d     = '0;
        cons_d     = '0;

        // Outputs are registered, so each one is set on the edge entering the state that shows it.
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    pc_d       = '0;
                    flags_d    = '0;
                    halted_d   = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                ctrl_d  = dec_ctrl;
                cons_d  = dec_cons;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_writes_flags(op)) begin
                    flags_d = Tags;
                end
                // imm is m bits wide, so a plain m-bit add is the sign-extended offset mod 2^m.
                case (op)
                    OP_BRZ:  if (flags_q[0]) pc_d = pc_q + imm;
                    OP_BRN:  if (flags_q[1]) pc_d = pc_q + imm;
                    OP_JMP:  pc_d = imm;
                    default: ;
                endcase
                if (op == OP_HLT) begin
                    halted_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
`ifdef PROCESADOR_STEP_EN
                    state_d    = ST_PAUSE;
`else
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
`endif
                end
            end
`ifdef PROCESADOR_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            flags_q    <= '0;
            halted_q   <= 1'b0;
            imem_req_q <= 1'b0;
            ctrl_q     <= '0;
            cons_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            halted_q   <= halted_d;
            imem_req_q <= imem_req_d;
            ctrl_q     <= ctrl_d;
            cons_q     <= cons_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign A_sel     = ctrl_q.a_sel;
    assign B_sel     = ctrl_q.b_sel;
    assign Dest_sel  = ctrl_q.dest_sel;
    assign H_sel     = ctrl_q.h_sel;
    assign G_sel     = ctrl_q.g_sel;
    assign MB_sel    = ctrl_q.mb_sel;
    assign MD_sel    = ctrl_q.md_sel;
    assign MF_sel    = ctrl_q.mf_sel;
    assign Load_en   = ctrl_q.load_en;
    assign mem_wr    = ctrl_q.mem_wr;
    assign Cons_IN   = cons_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_procesador_control_unit.sv
// Scoreboard bench for procesador_control_unit: serves instructions over the
// fetch handshake and compares each EXEC control word against a decode model.
module tb_procesador_control_unit;

    localparam int M = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           imem_req;
    logic [M-1:0]   imem_addr;
    logic           imem_valid;
    logic [2*M-1:0] imem_data;
    logic [3:0]     Tags;
    logic [1:0]     A_sel, B_sel, Dest_sel, H_sel;
    logic [3:0]     G_sel;
    logic           MB_sel, MD_sel, MF_sel, Load_en, mem_wr, halted;
    logic [M-1:0]   Cons_IN;
`ifdef PROCESADOR_STEP_EN
    logic           step = 1'b0;
`endif

    always #5 clk = ~clk;

    procesador_control_unit #(.m(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
`ifdef PROCESADOR_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .Tags       (Tags),
        .A_sel      (A_sel),
        .B_sel      (B_sel),
        .Dest_sel   (Dest_sel),
        .H_sel      (H_sel),
        .G_sel      (G_sel),
        .MB_sel     (MB_sel),
        .MD_sel     (MD_sel),
        .MF_sel     (MF_sel),
        .Load_en    (Load_en),
        .Cons_IN    (Cons_IN),
        .mem_wr     (mem_wr),
        .halted     (halted)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  exp_pc;
    logic [3:0]  exp_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {A,B,Dest,H,G,MB,MD,MF,Load,mem_wr,Cons}
    function automatic logic [24:0] ctrl_vec();
        return {A_sel, B_sel, Dest_sel, H_sel, G_sel, MB_sel, MD_sel, MF_sel,
                Load_en, mem_wr, Cons_IN};
    endfunction

    function automatic logic [24:0] model_ctrl(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] a, b, d, h;
        logic [3:0] g;
        logic       mb, md, mf, ld, wr;
        logic [7:0] c;
        op = ins[15:12];
        {a, b, d, h, g, mb, md, mf, ld, wr, c} = '0;
        case (op)
            4'h1: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b0010; end
            4'h2: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b0101; end
            4'h3: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b1000; end
            4'h4: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b1010; end
            4'h5: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b1100; end
            4'h6: begin d = ins[11:10]; a = ins[9:8]; b = ins[1:0]; ld = 1; g = 4'b0010;
                        mb = 1; c = ins[7:0]; end
            4'h7: begin d = ins[11:10]; a = ins[9:8]; ld = 1; end
            4'h8: begin d = ins[11:10]; b = ins[1:0]; mf = 1; h = 2'b01; ld = 1; end
            4'h9: begin d = ins[11:10]; b = ins[1:0]; mf = 1; h = 2'b10; ld = 1; end
            4'hA: begin d = ins[11:10]; a = ins[9:8]; md = 1; ld = 1; end
            4'hB: begin a = ins[9:8]; b = ins[1:0]; wr = 1; end
            default: ;
        endcase
        return {a, b, d, h, g, mb, md, mf, ld, wr, c};
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic exec_instr(input logic [15:0] ins, input int waits, input logic [3:0] tg);
        logic [3:0] op;
        op = ins[15:12];
        wait_req();
        check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
        check("fetch_ctrl_zero", 32'(ctrl_vec()), 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("req_hold", 32'(imem_req), 32'd1);
        end
        imem_valid = 1'b1;
        imem_data  = ins;
        exp_q.push_back(model_ctrl(ins));
        exp_pc = exp_pc + 8'd1;
        @(negedge clk);
        check("decode_quiet", {6'd0, imem_req, ctrl_vec()}, 32'd0);
        // valid held through DECODE with a HLT word; must be ignored
        imem_data = 16'hF000;
        @(negedge clk);
        imem_valid = 1'b0;
        Tags = tg;
        check("exec_ctrl", 32'(ctrl_vec()), 32'(exp_q.pop_front()));
        check("exec_pc", 32'(imem_addr), 32'(exp_pc));
        case (op)
            4'hC: if (exp_flags[0]) exp_pc = exp_pc + ins[7:0];
            4'hD: if (exp_flags[1]) exp_pc = exp_pc + ins[7:0];
            4'hE: exp_pc = ins[7:0];
            default: ;
        endcase
        if (op >= 4'h1 && op <= 4'h9) exp_flags = tg;
        @(negedge clk);
        Tags = 4'($urandom);
        check("post_exec_ctrl", 32'(ctrl_vec()), 32'd0);
        if (op == 4'hF) begin
            check("halted_set", 32'(halted), 32'd1);
            check("halt_no_req", 32'(imem_req), 32'd0);
        end else begin
`ifdef PROCESADOR_STEP_EN
            for (int i = 0; i < 2; i++) begin
                check("pause_stall", 32'(imem_req), 32'd0);
                @(negedge clk);
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
`endif
            check("next_fetch_req", 32'(imem_req), 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        imem_valid = 1'b0;
        imem_data  = '0;
        Tags       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {5'd0, imem_req, halted, imem_addr, ctrl_vec()} , 32'd0);

        run = 1'b1;
        @(negedge clk);
        run       = 1'b0;
        exp_pc    = 8'd0;
        exp_flags = 4'd0;

        exec_instr(16'h6404, 2, 4'h0);
        exec_instr(16'h1D02, 0, 4'h0);
        exec_instr(16'hB001, 1, 4'h0);
        exec_instr(16'h8A01, 0, 4'h0);
        exec_instr(16'h2102, 0, 4'h1);
        exec_instr(16'hC0FE, 0, 4'h0);
        check("brz_taken_addr", 32'(imem_addr), 32'd4);
        exec_instr(16'h2102, 0, 4'h0);
        exec_instr(16'hC0FE, 0, 4'h0);
        check("brz_not_taken_addr", 32'(imem_addr), 32'd6);
        exec_instr(16'h1102, 0, 4'h2);
        exec_instr(16'hD003, 0, 4'h0);
        check("brn_taken_addr", 32'(imem_addr), 32'd11);
        exec_instr(16'hE0FF, 0, 4'h0);
        run = 1'b1;
        exec_instr(16'h7400, 1, 4'h0);
        run = 1'b0;
        check("pc_wrap_addr", 32'(imem_addr), 32'd0);
        exec_instr(16'hA900, 0, 4'h0);
        exec_instr(16'h3C01, 1, 4'h0);
        exec_instr(16'h4D02, 0, 4'h0);
        exec_instr(16'h5E03, 0, 4'h0);
        exec_instr(16'h9B02, 0, 4'h0);
        exec_instr(16'h0000, 0, 4'h0);
        exec_instr(16'h2102, 0, 4'h1);
        exec_instr(16'hF000, 0, 4'h0);

        repeat (3) begin
            @(negedge clk);
            check("idle_no_req", {30'd0, imem_req, halted}, 32'd1);
        end
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("restart", {22'd0, imem_req, halted, imem_addr}, {22'd0, 2'b10, 8'h00});
        exp_pc    = 8'd0;
        exp_flags = 4'd0;
        exec_instr(16'hC005, 0, 4'h0);
        check("flags_cleared_addr", 32'(imem_addr), 32'd1);

        wait_req();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_fetch", {5'd0, imem_req, halted, imem_addr, ctrl_vec()}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_fetch_abandoned", 32'(imem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/procesador_control_unit.md
# procesador_control_unit

Sequencing control unit that drives the `Procesador` datapath. It fetches `2*m`-bit instructions from an external instruction memory over a request/valid handshake and decodes each one into the datapath control word (`A_sel`, `B_sel`, `Dest_sel`, `H_sel`, `G_sel`, `MB_sel`, `MD_sel`, `MF_sel`, `Load_en`, `Cons_IN`). It samples the datapath `Tags` to resolve conditional branches. It sits between instruction memory and `Procesador`, replacing hand-driven control words.

## Interface
- `m`, default 8: datapath width. PC width is `m`; instruction width is `2*m`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  start request, sampled in IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  m  fetch address (= PC).
- `imem_valid`  in  1  instruction word present on `imem_data`.
- `imem_data`  in  2*m  instruction word.
- `Tags`  in  4  datapath flags {V,C,N,Z}; Z = bit 0.
- `A_sel`, `B_sel`, `Dest_sel`, `H_sel`  out  2 each  datapath selects.
- `G_sel`  out  4  ALU function.
- `MB_sel`, `MD_sel`, `MF_sel`, `Load_en`  out  1 each  datapath mux selects and register write enable.
- `Cons_IN`  out  m  immediate.
- `mem_wr`  out  1  data memory write strobe (address = bus A, data = bus B).
- `halted`  out  1  HLT executed; held until the next run.

## Operation
- Instruction fields: op[15:12], dr[11:10], sa[9:8], imm[7:0]; sb = imm[1:0].
- G codes: 0000 F=A; 0010 A+B; 0101 A+~B+1; 1000 AND; 1010 OR; 1100 XOR.
- H codes: 00 pass; 01 shift left; 10 shift right; 11 zero.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: Dest_sel=dr, A_sel=sa, B_sel=sb, MB=0, MF=0, MD=0, Load_en=1.
  - 6 ADI: as ADD but MB=1, Cons_IN=imm.
  - 7 MOV: G=0000.
  - 8 SHL, 9 SHR: B_sel=sb, MF=1, H=01 or 10.
  - A LD: MD=1, A_sel=sa, Load_en=1.
  - B ST: A_sel=sa, B_sel=sb, mem_wr=1, Load_en=0.
  - C BRZ, D BRN: if the latched Z or N flag is set, PC ← PC + sext(imm), mod 2^m.
  - E JMP: PC ← imm.
  - F HLT.
- FSM:
  - IDLE: on run=1, PC←0, flags←0, halted←0, go to FETCH.
  - FETCH: imem_req=1. On imem_valid: IR←imem_data, PC←PC+1, go to DECODE.
  - DECODE: one cycle; go to EXEC.
  - EXEC: control word driven for exactly one cycle. HLT goes to IDLE with halted←1; all other opcodes go to FETCH.
- Flag register ← Tags at the end of EXEC for opcodes 1–9 only; branches test this register.
- Outside EXEC, every control output is 0, so `Load_en`, `mem_wr` and `MD_sel` can only pulse in EXEC.
- Reset values: state IDLE; PC, IR and flags 0; every output 0, including `halted` and `imem_req`.

## Timing
- Instruction takes 3 cycles minimum: FETCH (1 + memory wait), DECODE, EXEC.
- `imem_req` holds until `imem_valid`. `imem_valid` outside FETCH is ignored.
- Branch target is relative to the already-incremented PC. PC wraps 2^m−1 → 0 silently.
- `run` is ignored outside IDLE. Only HLT or `rst` stops execution.
- `rst` mid-FETCH: `imem_req` is low the next cycle and the fetch is abandoned.
- `rst` in EXEC: that cycle's control word still drives the datapath; no further pulses occur.

## Configuration
- `PROCESADOR_STEP_EN` defined: adds input `step` (1 bit) and state PAUSE. EXEC of any non-HLT opcode goes to PAUSE, which waits for step=1 and then goes to FETCH.
- Undefined: no `step` port; EXEC goes straight to FETCH.

## Structure
- `procesador_pkg`: opcode enum, FSM state enum, G and H code constants, packed control-word struct.
- Sub-module `procesador_decoder`: combinational IR → control word. The FSM gates its output with the EXEC state.

## Test plan
- Reset, run=1, memory returns 0x6404 (ADI R1,R0,#4) with a 2-cycle wait → EXEC shows Dest_sel=01, A_sel=00, MB_sel=1, Cons_IN=0x04, G_sel=0010, Load_en=1 for one cycle; PC=1.
- 0x1D02 (ADD R3,R1,R2) → A_sel=01, B_sel=10, Dest_sel=11, MF_sel=0, Load_en=1; 3 cycles with zero wait.
- SUB with Tags=0001 in EXEC, then BRZ 0xC0FE at PC=5 → next `imem_addr`=4. Same sequence with Tags=0000 → next `imem_addr`=6.
- ST 0xB0_01 → mem_wr=1, Load_en=0 for exactly one cycle; 0x8A01 (SHL) → MF_sel=1, H_sel=01.
- 0xF000 → `halted`=1, state IDLE, no further `imem_req`; run=1 restarts at `imem_addr`=0 and clears `halted`.
- `rst` asserted mid-FETCH → all outputs 0 next cycle. With `PROCESADOR_STEP_EN`, the FSM stalls after EXEC until `step`=1.
